opram_loader: RTL and testbench

Byte-stream sequencer that sits directly upstream of the 8-entry × 8-bit operand RAM and downstream of the instruction fetch stream. It accepts one instruction's bytes (opcode plus operands) over a valid/ready input and writes them into the RAM at addresses 0..N-1. It then reads them back in order and presents them one at a time to the execute stage over a valid/ready output, tagged with an index and a last flag.

---
 rtl/opram_loader.sv | 145 ++++++++++++++
 tb/tb_opram_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opram_loader.sv
// Loads one instruction's bytes into the operand RAM, then replays them in order
// to the execute stage with index and last tags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an opcode; a byte accepted here lands at address 0
// LOAD    | accepting operand bytes at wptr until len_r bytes are stored
// ISSUE   | RAM read issued at rptr
// CAPT    | RAM read data captured into the output registers
// PRESENT | out_valid high, holding until out_ready
module opram_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ram_ce,
    output logic       ram_oce,
    output logic       ram_wre,
    output logic [2:0] ram_ad,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout,
    output logic [7:0] out_data,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPT    = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    state_t     state;
    logic [2:0] wptr;
    logic [2:0] rptr;
    logic [3:0] len_r;
    logic       accept;

    assign in_ready = ((state == S_IDLE) || (state == S_LOAD)) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_IDLE);
    assign ram_oce  = 1'b1;

    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_ad  = 3'd0;
        ram_din = 8'd0;
        case (state)
            S_IDLE: begin
                ram_ce  = accept;
                ram_wre = accept;
                ram_din = in_data;
            end
            S_LOAD: begin
                ram_ce  = accept;
                ram_wre = accept;
                ram_ad  = wptr;
                ram_din = in_data;
            end
            S_ISSUE: begin
                ram_ce = 1'b1;
                ram_ad = rptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wptr      <= 3'd0;
            rptr      <= 3'd0;
            len_r     <= 4'd0;
            out_data  <= 8'd0;
            out_idx   <= 3'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            // Output registers keep their last value; only out_valid is dropped.
            state     <= S_IDLE;
            wptr      <= 3'd0;
            rptr      <= 3'd0;
            len_r     <= 4'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        len_r <= {1'b0, in_data[2:0]} + 4'd1;
                        if (in_data[2:0] == 3'd0) begin
                            state <= S_ISSUE;
                        end else begin
                            wptr  <= 3'd1;
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if ({1'b0, wptr} == len_r - 4'd1) begin
                            state <= S_ISSUE;
                        end else begin
                            wptr <= wptr + 3'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    out_data  <= ram_dout;
                    out_idx   <= rptr;
                    out_last  <= ({1'b0, rptr} == len_r - 4'd1);
                    out_valid <= 1'b1;
                    state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            rptr  <= 3'd0;
                            wptr  <= 3'd0;
                            state <= S_IDLE;
                        end else begin
                            rptr  <= rptr + 3'd1;
                            state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opram_loader.sv
// Scoreboard bench for opram_loader: RAM writes and output bytes are queued as
// expectations and popped by independent monitors.
module tb_opram_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ram_ce, ram_oce, ram_wre;
    logic [2:0] ram_ad;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [7:0] out_data;
    logic [2:0] out_idx;
    logic       out_last, out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int last_hs = 0;
    logic chk_spacing = 1'b0;

    logic [10:0] wq[$];   // {ad, din}
    logic [11:0] oq[$];   // {data, idx, last}
    logic [7:0]  mem[8];

    opram_loader dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
        .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural operand RAM: read data appears the cycle after the read.
    always @(posedge clk)
        if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;

    always @(posedge clk or posedge reset)
        if (reset) ram_dout <= 8'd0;
        else if (ram_ce && !ram_wre) ram_dout <= mem[ram_ad];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    always @(negedge clk) begin
        if (!reset && ram_ce && ram_wre) begin
            if (wq.size() == 0) fail_now("ram_write_unexpected");
            else check("ram_write", {ram_ad, ram_din}, wq.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (oq.size() == 0) fail_now("out_unexpected");
            else check("out_byte", {out_data, out_idx, out_last}, oq.pop_front());
            if (chk_spacing && out_idx != 3'd0) check("out_spacing", cyc - last_hs, 3);
            last_hs = cyc;
        end
    end

    task automatic send(input logic [2:0] ad, input logic [7:0] b);
        int n = 0;
        wq.push_back({ad, b});
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic stop_in();
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || oq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy || oq.size() != 0) fail_now("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input logic [2:0] idx);
        int n = 0;
        @(negedge clk);
        while (!(out_valid && out_idx == idx) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(out_valid && out_idx == idx)) fail_now("out_wait_timeout");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'd0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_regs", {out_data, out_idx, out_last}, 0);
        check("rst_ram_ctl", {ram_ce, ram_wre, ram_ad, ram_din}, 0);
        check("rst_ram_oce", ram_oce, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // single-byte instruction
        oq.push_back({8'h00, 3'd0, 1'b1});
        send(3'd0, 8'h00);
        stop_in();
        @(negedge clk);
        check("t1_issue_read", {ram_ce, ram_wre, ram_ad}, {1'b1, 1'b0, 3'd0});
        check("t1_lat1", out_valid, 0);
        @(negedge clk);
        check("t1_lat2", out_valid, 0);
        @(negedge clk);
        check("t1_lat3", out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_idle_ready", in_ready, 1);
        check("t1_idle_busy", busy, 0);
        @(posedge clk); #1;

        // full 8-byte instruction, back-to-back
        chk_spacing = 1'b1;
        oq.push_back({8'h07, 3'd0, 1'b0});
        for (int i = 1; i < 8; i++)
            oq.push_back({8'(i * 8'h11), 3'(i), (i == 7)});
        send(3'd0, 8'h07);
        for (int i = 1; i < 8; i++) send(3'(i), 8'(i * 8'h11));
        stop_in();
        wait_idle();
        chk_spacing = 1'b0;

        // input gaps plus back-pressure on idx 1
        oq.push_back({8'h02, 3'd0, 1'b0});
        oq.push_back({8'hA5, 3'd1, 1'b0});
        oq.push_back({8'h5A, 3'd2, 1'b1});
        send(3'd0, 8'h02);
        stop_in(); repeat (2) @(posedge clk); #1;
        send(3'd1, 8'hA5);
        stop_in(); repeat (3) @(posedge clk); #1;
        send(3'd2, 8'h5A);
        stop_in();
        wait_out(3'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_out(3'd1);
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_valid", out_valid, 1);
            check("t3_stall_data", out_data, 8'hA5);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();

        // flush during LOAD, with a byte presented in the flush cycle
        send(3'd0, 8'h05);
        send(3'd1, 8'h10);
        send(3'd2, 8'h20);
        in_data = 8'h99;
        flush   = 1'b1;
        @(negedge clk);
        check("t4_flush_in_ready", in_ready, 0);
        check("t4_flush_wre", ram_wre, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        stop_in();
        @(negedge clk);
        check("t4_flush_busy", busy, 0);
        check("t4_flush_ready", in_ready, 1);
        @(posedge clk); #1;
        oq.push_back({8'h01, 3'd0, 1'b0});
        oq.push_back({8'hEE, 3'd1, 1'b1});
        send(3'd0, 8'h01);
        send(3'd1, 8'hEE);
        stop_in();
        wait_idle();
        in_data  = 8'h33;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("t4_idle_flush_wre", ram_wre, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        stop_in();
        @(negedge clk);
        check("t4_idle_flush_busy", busy, 0);
        @(posedge clk); #1;

        // asynchronous reset while presenting
        out_ready = 1'b0;
        send(3'd0, 8'h01);
        send(3'd1, 8'h44);
        stop_in();
        wait_out(3'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_out_regs", {out_data, out_idx, out_last}, 0);
        check("t5_rst_ram_ctl", {ram_ce, ram_wre, ram_ad, ram_din}, 0);
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        oq.push_back({8'h01, 3'd0, 1'b0});
        oq.push_back({8'h66, 3'd1, 1'b1});
        send(3'd0, 8'h01);
        send(3'd1, 8'h66);
        stop_in();
        wait_idle();

        check("end_wq_empty", wq.size(), 0);
        check("end_oq_empty", oq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
